// File: rtl/xoodyak_pkg.sv
// Shared types and frame layout for the xoodyak host byte bridge.
package xoodyak_pkg;

    typedef enum logic [1:0] {StRx, StStart, StWait, StTx} state_e;

    typedef enum logic [2:0] {FldHdr, FldKey, FldNonce, FldAd, FldText, FldTag} field_e;

    localparam int unsigned FRAME_IN_BYTES  = 89;
    localparam int unsigned FRAME_OUT_BYTES = 41;

    localparam int unsigned KEY_OFF   = 1;
    localparam int unsigned NONCE_OFF = 17;
    localparam int unsigned AD_OFF    = 33;
    localparam int unsigned TEXT_OFF  = 49;
    localparam int unsigned TAG_OFF   = 73;

    localparam int unsigned VERIFY_BIT  = 0;
    localparam int unsigned TIMEOUT_BIT = 1;

    // Maps a request-frame byte index to the field it belongs to.
    function automatic field_e field_of(input int unsigned idx);
        field_e f;
        if (idx < KEY_OFF) begin
            f = FldHdr;
        end else if (idx < NONCE_OFF) begin
            f = FldKey;
        end else if (idx < AD_OFF) begin
            f = FldNonce;
        end else if (idx < TEXT_OFF) begin
            f = FldAd;
        end else if (idx < TAG_OFF) begin
            f = FldText;
        end else begin
            f = FldTag;
        end
        return f;
    endfunction

endpackage

// File: rtl/xoodyak_byte_serializer.sv
// Parallel-load byte shift register emitting MSB-first over a valid/ready link.
module xoodyak_byte_serializer
    import xoodyak_pkg::*;
#(
    parameter int unsigned NumBytes = FRAME_OUT_BYTES
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  load_i,
    input  logic [NumBytes*8-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [7:0]            data_o,
    output logic                  last_o,
    output logic                  done_o
);

    localparam int unsigned CntW = $clog2(NumBytes);

    logic [NumBytes*8-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  valid_q, valid_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        done_o  = 1'b0;
        if (load_i) begin
            shreg_d = data_i;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (valid_q && ready_i) begin
            // Shifting in zeros leaves the register clear once the frame drains.
            shreg_d = {shreg_q[NumBytes*8-9:0], 8'h00};
            if (cnt_q == CntW'(NumBytes - 1)) begin
                cnt_d   = '0;
                valid_d = 1'b0;
                done_o  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = shreg_q[NumBytes*8-1 -: 8];
    assign last_o  = valid_q && (cnt_q == CntW'(NumBytes - 1));

endmodule

// File: rtl/xoodyak_host_bridge.sv
// Host byte-stream front end for one xoodyak AEAD core: request deserialiser,
// core sequencing with timeout, and response serialiser.
module xoodyak_host_bridge
    import xoodyak_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CNTW        = 7
) (
    input  logic         eph1,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   out_data,
    output logic         out_last,
    output logic         busy,
    output logic         err_len,
    output logic         core_start,
    output logic         core_opmode,
    output logic [127:0] core_key,
    output logic [127:0] core_nonce,
    output logic [127:0] core_assodata,
    output logic [191:0] core_textin,
    output logic [127:0] core_verif,
    input  logic [191:0] core_textout,
    input  logic [127:0] core_authdata,
    input  logic         core_sqzdone,
    input  logic         core_verify
);

    localparam int unsigned WaitW = $clog2(TIMEOUT_CYC) + 1;

    state_e          state_q, state_d;
    logic            alive_q;
    logic [CNTW-1:0] rx_cnt_q, rx_cnt_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic            err_len_q, err_len_d;

    logic            opmode_q, opmode_d;
    logic [127:0]    key_q, key_d;
    logic [127:0]    nonce_q, nonce_d;
    logic [127:0]    ad_q, ad_d;
    logic [191:0]    text_q, text_d;
    logic [127:0]    tag_q, tag_d;

    logic                         rx_fire;
    logic                         tx_load;
    logic                         tx_done;
    logic [FRAME_OUT_BYTES*8-1:0] tx_data;
    logic [7:0]                   status;

    // alive_q keeps in_ready low while reset is held and for the first edge after.
    assign in_ready = alive_q && (state_q == StRx);
    assign rx_fire  = in_valid && in_ready;
    assign busy     = (state_q != StRx);
    assign err_len  = err_len_q;

    assign core_opmode   = opmode_q;
    assign core_key      = key_q;
    assign core_nonce    = nonce_q;
    assign core_assodata = ad_q;
    assign core_textin   = text_q;
    assign core_verif    = tag_q;

    always_comb begin
        opmode_d = opmode_q;
        key_d    = key_q;
        nonce_d  = nonce_q;
        ad_d     = ad_q;
        text_d   = text_q;
        tag_d    = tag_q;
        if (rx_fire) begin
            case (field_of(32'(rx_cnt_q)))
                FldHdr:   opmode_d = in_data[0];
                FldKey:   key_d    = {key_q[119:0], in_data};
                FldNonce: nonce_d  = {nonce_q[119:0], in_data};
                FldAd:    ad_d     = {ad_q[119:0], in_data};
                FldText:  text_d   = {text_q[183:0], in_data};
                FldTag:   tag_d    = {tag_q[119:0], in_data};
                default:  ;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        rx_cnt_d   = rx_cnt_q;
        wait_cnt_d = wait_cnt_q;
        err_len_d  = 1'b0;
        core_start = 1'b0;
        tx_load    = 1'b0;
        tx_data    = '0;
        status     = '0;
        unique case (state_q)
            StRx: begin
                if (rx_fire) begin
                    if (rx_cnt_q == CNTW'(FRAME_IN_BYTES - 1)) begin
                        rx_cnt_d = '0;
                        state_d  = StStart;
                    end else if (in_last) begin
                        rx_cnt_d  = '0;
                        err_len_d = 1'b1;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end
            end
            StStart: begin
                core_start = 1'b1;
                wait_cnt_d = '0;
                state_d    = StWait;
            end
            StWait: begin
                // Completion takes priority over a timeout in the same cycle.
                if (core_sqzdone) begin
                    status[VERIFY_BIT] = core_verify & opmode_q;
                    tx_data = {core_textout, core_authdata, status};
                    tx_load = 1'b1;
                    state_d = StTx;
                end else if (wait_cnt_q == WaitW'(TIMEOUT_CYC - 2)) begin
                    status[TIMEOUT_BIT] = 1'b1;
                    tx_data = {{((FRAME_OUT_BYTES - 1) * 8){1'b0}}, status};
                    tx_load = 1'b1;
                    state_d = StTx;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StTx: begin
                if (tx_done) begin
                    state_d = StRx;
                end
            end
            default: state_d = StRx;
        endcase
    end

    always_ff @(posedge eph1 or negedge reset) begin
        if (!reset) begin
            state_q    <= StRx;
            alive_q    <= 1'b0;
            rx_cnt_q   <= '0;
            wait_cnt_q <= '0;
            err_len_q  <= 1'b0;
            opmode_q   <= 1'b0;
            key_q      <= '0;
            nonce_q    <= '0;
            ad_q       <= '0;
            text_q     <= '0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            alive_q    <= 1'b1;
            rx_cnt_q   <= rx_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            err_len_q  <= err_len_d;
            opmode_q   <= opmode_d;
            key_q      <= key_d;
            nonce_q    <= nonce_d;
            ad_q       <= ad_d;
            text_q     <= text_d;
            tag_q      <= tag_d;
        end
    end

    xoodyak_byte_serializer #(
        .NumBytes(FRAME_OUT_BYTES)
    ) u_ser (
        .clk_i  (eph1),
        .rst_ni (reset),
        .load_i (tx_load),
        .data_i (tx_data),
        .valid_o(out_valid),
        .ready_i(out_ready),
        .data_o (out_data),
        .last_o (out_last),
        .done_o (tx_done)
    );

endmodule

// File: tb/tb_xoodyak_host_bridge.sv
// Directed bench for xoodyak_host_bridge with a toy core stub and a byte-level response model.
module tb_xoodyak_host_bridge;

    localparam int unsigned TO  = 16;
    localparam int          LAT = 4;

    localparam logic [127:0] KEY   = 128'h303132333435363738393a3b3c3d3e3f;
    localparam logic [127:0] NONCE = 128'h4142434445464748494a4b4c4d4e4f50;
    localparam logic [127:0] AD    = 128'h6162636465666768696a6b6c6d6e6f70;
    localparam logic [191:0] TXT   = 192'h4142434445464748494a4b4c4d4e4f505152535455565758;

    logic         eph1 = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = 8'h00;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [7:0]   out_data;
    logic         out_last;
    logic         busy;
    logic         err_len;
    logic         core_start;
    logic         core_opmode;
    logic [127:0] core_key, core_nonce, core_assodata, core_verif;
    logic [191:0] core_textin;
    logic [191:0] core_textout = '0;
    logic [127:0] core_authdata = '0;
    logic         core_sqzdone = 1'b0;
    logic         core_verify = 1'b0;

    xoodyak_host_bridge #(
        .TIMEOUT_CYC(TO),
        .CNTW       (7)
    ) dut (
        .eph1         (eph1),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .err_len      (err_len),
        .core_start   (core_start),
        .core_opmode  (core_opmode),
        .core_key     (core_key),
        .core_nonce   (core_nonce),
        .core_assodata(core_assodata),
        .core_textin  (core_textin),
        .core_verif   (core_verif),
        .core_textout (core_textout),
        .core_authdata(core_authdata),
        .core_sqzdone (core_sqzdone),
        .core_verify  (core_verify)
    );

    initial forever #5 eph1 = ~eph1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    initial forever begin
        @(posedge eph1);
        cyc++;
    end

    // Model state
    logic [7:0]   exp_q[$];
    logic [7:0]   resp[0:40];
    int           resp_idx = 0;
    logic         exp_op = 1'b0;
    logic [127:0] exp_key = '0, exp_nonce = '0, exp_ad = '0, exp_tag = '0;
    logic [191:0] exp_text = '0;
    int start_cnt = 0, err_cnt = 0;
    int start_cyc = -1, first_tx_cyc = -1, sqz_cyc = -1;
    int last_acc_cyc = -1, short_cyc = -1, err_cyc = -1;
    int fr_idx = 0;
    bit tx_seen = 1'b0;
    bit stub_en = 1'b1;
    bit spur_req = 1'b0;
    int stub_cnt = 0;
    logic       prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
    logic [7:0] prev_d = 8'h00;
    logic       err_prev = 1'b0;
    logic [7:0]   e_byte;
    logic [127:0] kn, tg_m;
    logic [191:0] pad, pt;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Compare process plus toy core: textout = textin ^ pad(key^nonce), tag from plaintext.
    initial forever begin
        @(negedge eph1);
        if (!reset) begin
            stub_cnt = 0;
            core_sqzdone = 1'b0;
            prev_v = 1'b0;
            fr_idx = 0;
            err_prev = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                if (fr_idx == 88) begin
                    last_acc_cyc = cyc;
                    fr_idx = 0;
                end else if (in_last) begin
                    short_cyc = cyc;
                    fr_idx = 0;
                end else begin
                    fr_idx++;
                end
            end
            if (err_len) begin
                err_cnt++;
                err_cyc = cyc;
                check("err_len_single", err_prev, 0);
            end
            err_prev = err_len;
            if (core_start) begin
                start_cnt++;
                start_cyc = cyc;
                tx_seen = 1'b0;
                check("start_latency", cyc, last_acc_cyc + 1);
                check("core_opmode", core_opmode, exp_op);
                check("core_key", core_key, exp_key);
                check("core_nonce", core_nonce, exp_nonce);
                check("core_assodata", core_assodata, exp_ad);
                check("core_textin", core_textin, exp_text);
                check("core_verif", core_verif, exp_tag);
                if (stub_en) stub_cnt = LAT;
            end
            if (out_valid && !tx_seen) begin
                tx_seen = 1'b1;
                first_tx_cyc = cyc;
            end
            if (prev_v && !prev_r) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_d);
                check("hold_last", out_last, prev_l);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_byte: got %0h with no byte expected", out_data);
                end else begin
                    e_byte = exp_q.pop_front();
                    check("out_data", out_data, e_byte);
                    check("out_last", out_last, exp_q.size() == 0);
                end
                if (resp_idx < 41) resp[resp_idx] = out_data;
                resp_idx++;
            end
            prev_v = out_valid;
            prev_r = out_ready;
            prev_d = out_data;
            prev_l = out_last;

            core_sqzdone = 1'b0;
            if (spur_req) begin
                core_sqzdone = 1'b1;
                spur_req = 1'b0;
            end else if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    check("key_stable_wait", core_key, exp_key);
                    check("text_stable_wait", core_textin, exp_text);
                    kn = core_key ^ core_nonce;
                    pad = {kn, kn[127:64]};
                    core_textout = core_textin ^ pad;
                    pt = core_opmode ? core_textout : core_textin;
                    tg_m = core_key ^ core_assodata ^ pt[191:64] ^ {pt[63:0], 64'h0};
                    core_authdata = tg_m;
                    core_verify = core_opmode ? (tg_m == core_verif) : 1'b1;
                    core_sqzdone = 1'b1;
                    sqz_cyc = cyc;
                    for (int i = 0; i < 24; i++) exp_q.push_back(core_textout[191-8*i -: 8]);
                    for (int i = 0; i < 16; i++) exp_q.push_back(tg_m[127-8*i -: 8]);
                    exp_q.push_back({7'b0, core_opmode & core_verify});
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] hdr, input logic [127:0] k, input logic [127:0] n,
                              input logic [127:0] a, input logic [191:0] t, input logic [127:0] g,
                              input int last_at);
        logic [7:0] fr[0:88];
        int tmo;
        fr[0] = hdr;
        for (int i = 0; i < 16; i++) begin
            fr[1+i]  = k[127-8*i -: 8];
            fr[17+i] = n[127-8*i -: 8];
            fr[33+i] = a[127-8*i -: 8];
            fr[73+i] = g[127-8*i -: 8];
        end
        for (int i = 0; i < 24; i++) fr[49+i] = t[191-8*i -: 8];
        if (last_at == 88) begin
            exp_op = hdr[0];
            exp_key = k;
            exp_nonce = n;
            exp_ad = a;
            exp_text = t;
            exp_tag = g;
        end
        for (int i = 0; i <= last_at; i++) begin
            in_valid = 1'b1;
            in_data = fr[i];
            in_last = (i == last_at);
            tmo = 0;
            @(negedge eph1);
            while (!in_ready && tmo < 200) begin
                @(negedge eph1);
                tmo++;
            end
            if (!in_ready) begin
                n_cmp++;
                n_bad++;
                $display("FAIL in_ready_timeout: byte %0d not accepted, required acceptance", i);
            end
            @(posedge eph1);
            #1;
            in_valid = 1'b0;
            in_last = 1'b0;
            if (i % 11 == 5) begin
                @(posedge eph1);
                #1;
            end
        end
    endtask

    task automatic wait_bytes(input string name, input int cnt);
        int t;
        t = 0;
        while (resp_idx < cnt && t < 400) begin
            @(posedge eph1);
            t++;
        end
        if (resp_idx < cnt) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got %0d bytes want %0d", name, resp_idx, cnt);
        end
    endtask

    task automatic finish_resp(input string name);
        wait_bytes(name, 41);
        repeat (3) @(posedge eph1);
        #1;
        check({name, "_count"}, resp_idx, 41);
        check({name, "_q_empty"}, exp_q.size(), 0);
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_idle_ready"}, in_ready, 1);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_in_ready"}, in_ready, 0);
        check({name, "_out_valid"}, out_valid, 0);
        check({name, "_out_data"}, out_data, 0);
        check({name, "_out_last"}, out_last, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_err_len"}, err_len, 0);
        check({name, "_core_start"}, core_start, 0);
        check({name, "_core_opmode"}, core_opmode, 0);
        check({name, "_core_key"}, core_key, 0);
        check({name, "_core_textin"}, core_textin, 0);
        check({name, "_core_verif"}, core_verif, 0);
    endtask

    initial begin
        logic [191:0] ct;
        logic [127:0] tg;
        int s0, e0, t;

        repeat (2) @(posedge eph1);
        #1;
        check_all_zero("rst");
        reset = 1'b1;
        repeat (2) @(posedge eph1);
        #1;
        check("rel_in_ready", in_ready, 1);
        check("rel_busy", busy, 0);

        // Encrypt
        resp_idx = 0;
        send_frame(8'h00, KEY, NONCE, AD, TXT, 128'h0, 88);
        finish_resp("enc");
        check("enc_start_cnt", start_cnt, 1);
        check("enc_out_latency", first_tx_cyc, sqz_cyc + 1);
        check("enc_ct0", resp[0], 8'h30);
        check("enc_ct15", resp[15], 8'h3f);
        check("enc_ct16", resp[16], 8'h20);
        check("enc_status", resp[40], 8'h00);
        for (int i = 0; i < 24; i++) ct[191-8*i -: 8] = resp[i];
        for (int i = 0; i < 16; i++) tg[127-8*i -: 8] = resp[24+i];

        // Decrypt round trip
        resp_idx = 0;
        send_frame(8'h01, KEY, NONCE, AD, ct, tg, 88);
        finish_resp("dec");
        for (int i = 0; i < 24; i++) check("dec_plain", resp[i], 8'(8'h41 + i));
        check("dec_status", resp[40], 8'h01);

        // Corrupted tag
        resp_idx = 0;
        send_frame(8'h01, KEY, NONCE, AD, ct, tg ^ 128'h1, 88);
        finish_resp("bad");
        check("bad_plain0", resp[0], 8'h41);
        check("bad_status", resp[40], 8'h00);

        // Short frame, in_last on the 10th byte
        s0 = start_cnt;
        e0 = err_cnt;
        send_frame(8'h00, KEY, NONCE, AD, TXT, 128'h0, 9);
        repeat (4) @(posedge eph1);
        #1;
        check("short_err_cnt", err_cnt - e0, 1);
        check("short_err_timing", err_cyc, short_cyc + 1);
        check("short_no_start", start_cnt - s0, 0);
        check("short_busy", busy, 0);

        // Completion pulse while idle must be ignored
        spur_req = 1'b1;
        repeat (4) @(posedge eph1);
        #1;
        check("spur_busy", busy, 0);
        check("spur_out_valid", out_valid, 0);

        // Back-pressure mid-response
        resp_idx = 0;
        send_frame(8'h00, KEY, NONCE, AD, TXT, 128'h0, 88);
        wait_bytes("bp_pre", 10);
        #1;
        out_ready = 1'b0;
        repeat (5) @(posedge eph1);
        #1;
        check("bp_valid_held", out_valid, 1);
        out_ready = 1'b1;
        finish_resp("bp");
        check("bp_ct0", resp[0], 8'h30);

        // Core never completes: timeout response, then reset mid-TX
        stub_en = 1'b0;
        resp_idx = 0;
        for (int i = 0; i < 40; i++) exp_q.push_back(8'h00);
        exp_q.push_back(8'h02);
        send_frame(8'h00, KEY, NONCE, AD, TXT, 128'h0, 88);
        wait_bytes("to_pre", 5);
        #1;
        check("to_latency", first_tx_cyc - start_cyc, 16);
        check("to_mid_tx", out_valid, 1);
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        exp_q.delete();
        @(posedge eph1);
        #1;
        reset = 1'b1;
        stub_en = 1'b1;
        repeat (2) @(posedge eph1);
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_busy", busy, 0);

        // Full timeout response, then recovery with junk header bits
        stub_en = 1'b0;
        resp_idx = 0;
        for (int i = 0; i < 40; i++) exp_q.push_back(8'h00);
        exp_q.push_back(8'h02);
        send_frame(8'h00, KEY, NONCE, AD, TXT, 128'h0, 88);
        finish_resp("to");
        check("to_status", resp[40], 8'h02);
        check("to_text0", resp[0], 8'h00);
        stub_en = 1'b1;
        resp_idx = 0;
        send_frame(8'hA0, KEY, NONCE, AD, TXT, 128'h0, 88);
        finish_resp("rec");
        check("rec_ct0", resp[0], 8'h30);
        check("rec_status", resp[40], 8'h00);

        t = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/xoodyak_host_bridge.md
Name: xoodyak_host_bridge

Overview:
Byte-stream front end for the xoodyak AEAD core. It deserialises a host request frame (opmode, key, nonce, associated data, text, tag) into the core's parallel input buses and pulses the core start. It then waits for core completion and serialises text, tag and a status byte back to the host. It sits between a valid/ready byte link (UART/FIFO side) and one xoodyak instance, and acts as the initiator/reader for that core's result bus.

Parameters:
TIMEOUT_CYC, 1024, max cycles in WAIT before the bridge abandons the core (>=2).
CNTW, 7, width of byte counters (must hold 88).

Ports:
eph1  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
in_valid  in  1  host byte valid
in_ready  out  1  bridge accepts byte
in_data  in  8  host byte
in_last  in  1  marks final byte of host frame
out_valid  out  1  response byte valid
out_ready  in  1  host accepts response byte
out_data  out  8  response byte
out_last  out  1  marks final response byte
busy  out  1  high outside RX state
err_len  out  1  one-cycle pulse on short frame
core_start  out  1  one-cycle start pulse to core
core_opmode  out  1  0 encrypt, 1 decrypt
core_key  out  128  key
core_nonce  out  128  nonce
core_assodata  out  128  associated data
core_textin  out  192  plaintext or ciphertext
core_verif  out  128  expected tag (decrypt)
core_textout  in  192  core text result
core_authdata  in  128  core tag result
core_sqzdone  in  1  core completion pulse
core_verify  in  1  tag match (valid with sqzdone, decrypt)

Behaviour:
- Reset (reset=0): state RX, counters 0, all outputs 0 incl. in_ready, all core_* buses 0.
- Input frame, 89 bytes, MSB-first per field: byte0 header (bit0 opmode, bits7:1 ignored); bytes1-16 key; 17-32 nonce; 33-48 AD; 49-72 text; 73-88 tag. First byte of a field lands in its top bits (key byte1 -> core_key[127:120]).
- Transfer occurs on eph1 edge with valid&ready high on both sides.
- RX: in_ready=1. Each accepted byte shifts into its field, rx_cnt++. in_last with rx_cnt<88: frame dropped, rx_cnt=0, err_len pulses next cycle, fields retain stale data, no core_start. Byte 88 accepted (in_last value ignored) -> START.
- START: one cycle, core_start=1, in_ready=0 -> WAIT. core_* input buses held stable from START until returning to RX.
- WAIT: wait_cnt++ each cycle. core_sqzdone=1 -> latch core_textout, core_authdata, status={6'b0,0,core_verify & core_opmode} into 41-byte tx shift register -> TX. wait_cnt reaching TIMEOUT_CYC-1 without sqzdone -> tx register text/tag zeros, status 8'h02 -> TX. sqzdone on the timeout cycle: sqzdone wins.
- TX: out_valid=1; order textout[191:184] first ... authdata MSB-first ... status last with out_last=1. out_data/out_last held stable while out_ready=0. After last byte accepted -> RX, tx_cnt=0; no bubble required beyond one cycle.
- core_sqzdone outside WAIT ignored.
- Reset asserted mid-operation: immediate return to reset values; partial frames lost.
- Latency: core_start one cycle after byte 88 accepted; out_valid one cycle after sqzdone.

Decomposition:
- xoodyak_pkg: state enum (RX, START, WAIT, TX), FRAME_IN_BYTES=89, FRAME_OUT_BYTES=41, field byte offsets, status bit positions (VERIFY_BIT=0, TIMEOUT_BIT=1).
- Sub-module xoodyak_byte_serializer: 41-byte parallel-load shift register with valid/ready/last handshake; FSM and deserialiser stay in the top.

Test Plan:
- Encrypt: header 8'h00, key 303132..3f, nonce 4142..50, AD 6162..70, text 4142..58, tag zeros, real core -> one core_start, 41 bytes equal core textout/authdata, status 8'h00.
- Decrypt round trip: header 8'h01 with ciphertext/tag from previous response -> status 8'h01, text bytes 4142..58.
- Tag corrupted (last tag byte xor 8'h01), decrypt -> status 8'h00.
- in_last on 10th byte -> err_len one pulse, no core_start, next full 89-byte frame processes normally.
- out_ready low 5 cycles mid-TX -> out_data/out_last stable; no byte lost or duplicated across 41.
- Stub core never asserting sqzdone, TIMEOUT_CYC=16 -> TX starts 16 cycles after core_start, 40 zero bytes then 8'h02; reset low mid-TX -> all outputs 0 same cycle, in_ready=1 after release.
